// File: rtl/ex_mem_stage.sv
// EX/MEM boundary: 2-entry skid buffer toward memory,
// branch/jump resolution and registered PC redirect.
module ex_mem_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [DATA_WIDTH-1:0]     ALUResult,
  input  logic [DATA_WIDTH-1:0]     ex_store_data,
  input  logic [DATA_WIDTH-1:0]     ex_pc_plus4,
  input  logic [DATA_WIDTH-1:0]     ex_branch_target,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic                      ex_mem_write,
  input  logic                      ex_branch,
  input  logic                      ex_jump,
  input  logic [2:0]                ex_funct3,
  input  logic                      flush,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [DATA_WIDTH-1:0]     mem_result,
  output logic [DATA_WIDTH-1:0]     mem_store_data,
  output logic [REG_ADDR_WIDTH-1:0] mem_rd,
  output logic [2:0]                mem_funct3,
  output logic                      mem_reg_write,
  output logic                      mem_mem_read,
  output logic                      mem_mem_write,
  output logic                      pc_redirect,
  output logic [DATA_WIDTH-1:0]     pc_target,
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0]     fwd_data
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     result;
    logic [DATA_WIDTH-1:0]     store_data;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [2:0]                funct3;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
  } ex_mem_t;

  ex_mem_t               out_q, out_d;
  ex_mem_t               skid_q, skid_d;
  ex_mem_t               new_entry;
  logic                  out_v_q, out_v_d;
  logic                  skid_v_q, skid_v_d;
  logic                  redirect_q, redirect_d;
  logic [DATA_WIDTH-1:0] target_q, target_d;
  logic                  squash;
  logic                  accept;
  logic                  drain;
  logic                  taken;

  assign ex_ready = !skid_v_q;
  assign squash   = redirect_q;
  assign accept   = ex_valid & ex_ready & !flush & !squash;
  assign drain    = out_v_q & mem_ready;
  assign taken    = ex_jump | (ex_branch & ALUResult[0]);

  always_comb begin
    new_entry.result     = ex_jump ? ex_pc_plus4 : ALUResult;
    new_entry.store_data = ex_store_data;
    new_entry.rd         = ex_rd;
    new_entry.funct3     = ex_funct3;
    new_entry.reg_write  = ex_reg_write & !ex_branch;
    new_entry.mem_read   = ex_mem_read & !ex_branch;
    new_entry.mem_write  = ex_mem_write & !ex_branch;
  end

  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_v_d    = out_v_q;
    skid_v_d   = skid_v_q;
    redirect_d = 1'b0;
    target_d   = target_q;
    unique case (1'b1)
      flush: begin
        out_v_d  = 1'b0;
        skid_v_d = 1'b0;
      end
      default: begin
        if (drain) begin
          out_v_d = skid_v_q;
          if (skid_v_q) begin
            out_d    = skid_q;
            skid_v_d = 1'b0;
          end
        end
        if (accept) begin
          if (!out_v_d) begin
            out_d   = new_entry;
            out_v_d = 1'b1;
          end else begin
            skid_d   = new_entry;
            skid_v_d = 1'b1;
          end
          if (taken) begin
            redirect_d = 1'b1;
            target_d   = ex_branch_target;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_v_q    <= 1'b0;
      skid_v_q   <= 1'b0;
      redirect_q <= 1'b0;
      target_q   <= '0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_v_q    <= out_v_d;
      skid_v_q   <= skid_v_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
    end
  end

  assign mem_valid      = out_v_q;
  assign mem_result     = out_q.result;
  assign mem_store_data = out_q.store_data;
  assign mem_rd         = out_q.rd;
  assign mem_funct3     = out_q.funct3;
  assign mem_reg_write  = out_v_q & out_q.reg_write;
  assign mem_mem_read   = out_v_q & out_q.mem_read;
  assign mem_mem_write  = out_v_q & out_q.mem_write;

  assign pc_redirect = redirect_q & !flush;
  assign pc_target   = target_q;

  assign fwd_valid = mem_valid & mem_reg_write & (mem_rd != '0);
  assign fwd_rd    = mem_rd;
  assign fwd_data  = mem_result;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed testbench for ex_mem_stage: streaming, backpressure,
// branch/jump redirect, squash, flush and reset.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ALUResult;
  logic [31:0] ex_store_data;
  logic [31:0] ex_pc_plus4;
  logic [31:0] ex_branch_target;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_jump;
  logic [2:0]  ex_funct3;
  logic        flush;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_result;
  logic [31:0] mem_store_data;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_funct3;
  logic        mem_reg_write;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .ALUResult       (ALUResult),
    .ex_store_data   (ex_store_data),
    .ex_pc_plus4     (ex_pc_plus4),
    .ex_branch_target(ex_branch_target),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write),
    .ex_branch       (ex_branch),
    .ex_jump         (ex_jump),
    .ex_funct3       (ex_funct3),
    .flush           (flush),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_result      (mem_result),
    .mem_store_data  (mem_store_data),
    .mem_rd          (mem_rd),
    .mem_funct3      (mem_funct3),
    .mem_reg_write   (mem_reg_write),
    .mem_mem_read    (mem_mem_read),
    .mem_mem_write   (mem_mem_write),
    .pc_redirect     (pc_redirect),
    .pc_target       (pc_target),
    .fwd_valid       (fwd_valid),
    .fwd_rd          (fwd_rd),
    .fwd_data        (fwd_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid     = 1'b0;
    ex_branch    = 1'b0;
    ex_jump      = 1'b0;
    ex_reg_write = 1'b0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
  endtask

  task automatic drive_alu(input logic [31:0] res, input logic [4:0] rd);
    idle();
    ex_valid      = 1'b1;
    ALUResult     = res;
    ex_rd         = rd;
    ex_reg_write  = 1'b1;
    ex_store_data = res ^ 32'hFFFF_0000;
    ex_funct3     = 3'd2;
  endtask

  task automatic drive_br(input logic [31:0] cond, input logic [31:0] tgt);
    idle();
    ex_valid         = 1'b1;
    ex_branch        = 1'b1;
    ex_reg_write     = 1'b1;
    ALUResult        = cond;
    ex_branch_target = tgt;
    ex_rd            = 5'd3;
  endtask

  task automatic test_reset();
    idle();
    flush     = 1'b0;
    mem_ready = 1'b1;
    ALUResult = '0; ex_store_data = '0; ex_pc_plus4 = '0;
    ex_branch_target = '0; ex_rd = '0; ex_funct3 = '0;
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    n_checks++;
    if (mem_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem_valid got %b want 0", mem_valid);
    end
    n_checks++;
    if (ex_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ex_ready got %b want 1", ex_ready);
    end
    n_checks++;
    if ({pc_redirect, pc_target} !== 33'd0) begin
      n_fail++; $display("FAIL reset_redirect got %b/%h want 0/0",
                         pc_redirect, pc_target);
    end
    n_checks++;
    if ({fwd_valid, mem_result, mem_reg_write, mem_mem_write} !== 35'd0) begin
      n_fail++; $display("FAIL reset_mem got %b %h %b %b want 0",
                         fwd_valid, mem_result, mem_reg_write, mem_mem_write);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = 32'h10 * (i + 1);
      drive_alu(exp, 5'(i + 1));
      n_checks++;
      if (ex_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_ready[%0d] got %b want 1", i, ex_ready);
      end
      step();
      n_checks++;
      if ({mem_valid, mem_result} !== {1'b1, exp}) begin
        n_fail++; $display("FAIL stream_out[%0d] got %b/%h want 1/%h",
                           i, mem_valid, mem_result, exp);
      end
    end
    idle();
    step();
    n_checks++;
    if (mem_valid !== 1'b0) begin
      n_fail++; $display("FAIL stream_empty got %b want 0", mem_valid);
    end
  endtask

  task automatic test_backpressure();
    mem_ready = 1'b0;
    drive_alu(32'h1, 5'd1);
    step();
    drive_alu(32'h2, 5'd2);
    step();
    n_checks++;
    if ({ex_ready, mem_result} !== {1'b0, 32'h1}) begin
      n_fail++; $display("FAIL bp_skid got %b/%h want 0/1", ex_ready, mem_result);
    end
    drive_alu(32'h3, 5'd3);
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if ({mem_valid, ex_ready, mem_result} !== {2'b10, 32'h1}) begin
        n_fail++; $display("FAIL bp_hold[%0d] got %b%b/%h want 10/1",
                           i, mem_valid, ex_ready, mem_result);
      end
    end
    mem_ready = 1'b1;
    step();
    n_checks++;
    if ({mem_valid, ex_ready, mem_result} !== {2'b11, 32'h2}) begin
      n_fail++; $display("FAIL bp_rel2 got %b%b/%h want 11/2",
                         mem_valid, ex_ready, mem_result);
    end
    step();
    n_checks++;
    if ({mem_valid, mem_result} !== {1'b1, 32'h3}) begin
      n_fail++; $display("FAIL bp_rel3 got %b/%h want 1/3", mem_valid, mem_result);
    end
    idle();
    step();
    n_checks++;
    if (mem_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_nodup got %b want 0", mem_valid);
    end
  endtask

  task automatic test_branch();
    mem_ready = 1'b1;
    drive_br(32'h1, 32'h100);
    step();
    n_checks++;
    if ({pc_redirect, pc_target} !== {1'b1, 32'h100}) begin
      n_fail++; $display("FAIL beq_taken got %b/%h want 1/100",
                         pc_redirect, pc_target);
    end
    n_checks++;
    if ({mem_valid, mem_reg_write} !== 2'b10) begin
      n_fail++; $display("FAIL beq_regwr got %b%b want 10",
                         mem_valid, mem_reg_write);
    end
    idle();
    step();
    n_checks++;
    if (pc_redirect !== 1'b0) begin
      n_fail++; $display("FAIL beq_pulse got %b want 0", pc_redirect);
    end
    drive_br(32'h0, 32'h180);
    step();
    n_checks++;
    if ({pc_redirect, mem_valid} !== 2'b01) begin
      n_fail++; $display("FAIL beq_not_taken got %b%b want 01",
                         pc_redirect, mem_valid);
    end
    idle();
    step();
  endtask

  task automatic test_jal();
    mem_ready = 1'b1;
    idle();
    ex_valid         = 1'b1;
    ex_jump          = 1'b1;
    ex_reg_write     = 1'b1;
    ex_pc_plus4      = 32'h48;
    ALUResult        = 32'h999;
    ex_rd            = 5'd1;
    ex_branch_target = 32'h200;
    step();
    n_checks++;
    if ({mem_result, fwd_valid, fwd_rd, fwd_data} !==
        {32'h48, 1'b1, 5'd1, 32'h48}) begin
      n_fail++; $display("FAIL jal_fwd got %h %b %0d %h want 48 1 1 48",
                         mem_result, fwd_valid, fwd_rd, fwd_data);
    end
    n_checks++;
    if ({pc_redirect, pc_target} !== {1'b1, 32'h200}) begin
      n_fail++; $display("FAIL jal_redirect got %b/%h want 1/200",
                         pc_redirect, pc_target);
    end
    drive_alu(32'h55, 5'd5);
    n_checks++;
    if (ex_ready !== 1'b1) begin
      n_fail++; $display("FAIL squash_ready got %b want 1", ex_ready);
    end
    step();
    n_checks++;
    if ({mem_valid, pc_redirect, mem_rd} !== {2'b00, 5'd1}) begin
      n_fail++; $display("FAIL squash_drop got %b%b rd=%0d want 00 rd=1",
                         mem_valid, pc_redirect, mem_rd);
    end
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b1;
    drive_br(32'h1, 32'h300);
    step();
    drive_br(32'h1, 32'h400);
    step();
    n_checks++;
    if ({pc_redirect, pc_target, mem_valid} !== {1'b0, 32'h300, 1'b0}) begin
      n_fail++; $display("FAIL b2b_second got %b/%h/%b want 0/300/0",
                         pc_redirect, pc_target, mem_valid);
    end
    idle();
    step();
  endtask

  task automatic test_flush();
    mem_ready = 1'b0;
    drive_alu(32'hA, 5'd2);
    step();
    idle();
    ex_valid         = 1'b1;
    ex_jump          = 1'b1;
    ex_reg_write     = 1'b1;
    ex_pc_plus4      = 32'h60;
    ex_rd            = 5'd4;
    ex_branch_target = 32'h500;
    step();
    drive_alu(32'hB, 5'd6);
    flush = 1'b1;
    #1;
    n_checks++;
    if ({pc_redirect, ex_ready, mem_valid} !== 3'b001) begin
      n_fail++; $display("FAIL flush_same got %b%b%b want 001",
                         pc_redirect, ex_ready, mem_valid);
    end
    step();
    flush = 1'b0;
    idle();
    n_checks++;
    if ({mem_valid, ex_ready, pc_redirect, mem_mem_read} !== 4'b0100) begin
      n_fail++; $display("FAIL flush_next got %b%b%b%b want 0100",
                         mem_valid, ex_ready, pc_redirect, mem_mem_read);
    end
    mem_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    drive_alu(32'h11, 5'd7);
    step();
    drive_alu(32'h22, 5'd8);
    step();
    n_checks++;
    if (ex_ready !== 1'b0) begin
      n_fail++; $display("FAIL rm_full got %b want 0", ex_ready);
    end
    idle();
    reset = 1'b0;
    step();
    reset = 1'b1;
    n_checks++;
    if ({mem_valid, ex_ready, pc_redirect, fwd_valid} !== 4'b0100) begin
      n_fail++; $display("FAIL rm_ctrl got %b%b%b%b want 0100",
                         mem_valid, ex_ready, pc_redirect, fwd_valid);
    end
    n_checks++;
    if ({mem_result, mem_rd, pc_target} !== 69'd0) begin
      n_fail++; $display("FAIL rm_data got %h %0d %h want 0",
                         mem_result, mem_rd, pc_target);
    end
    mem_ready = 1'b1;
    drive_alu(32'h7, 5'd0);
    step();
    n_checks++;
    if ({mem_valid, mem_reg_write, fwd_valid} !== 3'b110) begin
      n_fail++; $display("FAIL rd0_fwd got %b%b%b want 110",
                         mem_valid, mem_reg_write, fwd_valid);
    end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_jal();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM boundary stage of the rv32i core: captures the ALU result plus the control and data travelling with it, buffers it in a 2-entry skid buffer with a valid/ready handshake toward the memory stage, resolves branches and jumps from the ALU compare result, and issues a registered PC redirect. It sits directly downstream of the ALU and upstream of data memory/writeback, and provides the EX-stage forwarding source.

## Interface
- DATA_WIDTH, 32, width of ALU result, store data, PCs
- REG_ADDR_WIDTH, 5, register index width
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- ex_valid  in  1  EX holds a valid instruction
- ex_ready  out  1  stage can accept this cycle
- ALUResult  in  DATA_WIDTH  ALU output; bit 0 is the branch-condition result for compare ops
- ex_store_data  in  DATA_WIDTH  rs2 value for stores
- ex_pc_plus4, ex_branch_target  in  DATA_WIDTH  link value and target address
- ex_rd  in  REG_ADDR_WIDTH  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump  in  1 each  decoded control
- ex_funct3  in  3  access size/sign for memory
- flush  in  1  kill all buffered and incoming instructions
- mem_valid  out  1  output entry valid
- mem_ready  in  1  memory stage consumes entry
- mem_result, mem_store_data  out  DATA_WIDTH  buffered result / store data
- mem_rd, mem_funct3  out  REG_ADDR_WIDTH / 3
- mem_reg_write, mem_mem_read, mem_mem_write  out  1 each
- pc_redirect  out  1  one-cycle pulse: fetch must load pc_target
- pc_target  out  DATA_WIDTH  redirect address
- fwd_valid  out  1  forwarding data valid; fwd_rd, fwd_data mirror mem_rd, mem_result

## Operation
- Storage: output register (OUT) and skid register (SKID), each with a valid bit.
- ex_ready = !SKID.valid (registered, no combinational path from mem_ready).
- Accept = ex_valid & ex_ready & !flush & !squash. Output drain = mem_valid & mem_ready.
- On accept: if OUT empty, or OUT draining and SKID empty, entry goes to OUT; else to SKID. On drain with SKID valid, SKID moves to OUT (FIFO order preserved); a simultaneous accept then lands in SKID.
- Captured result: ex_jump ? ex_pc_plus4 : ALUResult. ex_branch forces stored reg_write, mem_read, mem_write to 0.
- taken = ex_jump | (ex_branch & ALUResult[0]). On accept of a taken instruction, redirect_q <= 1, target_q <= ex_branch_target; else redirect_q <= 0.
- pc_redirect = redirect_q & !flush; pc_target = target_q.
- squash = redirect_q: any ex_valid beat in the redirect cycle is wrong-path; it is consumed (ex_ready still high) and discarded, no state or redirect change.
- flush: clears OUT.valid, SKID.valid, redirect_q next edge; suppresses accept that cycle; flush outranks accept, drain and squash.
- fwd_valid = mem_valid & mem_reg_write & (mem_rd != 0).
- Invalid entries: data fields hold last value; all enables (mem_reg_write, mem_mem_read, mem_mem_write) gated to 0 when !mem_valid.

## Timing
- Reset (reset=0 at edge): OUT.valid, SKID.valid, redirect_q = 0; data regs = 0. Outputs: mem_valid 0, ex_ready 1, pc_redirect 0, pc_target 0, fwd_valid 0, all mem_* 0. Reset mid-operation discards all entries, no redirect.
- Latency: accepted beat appears on mem_* the next cycle (1 cycle) when OUT free; pc_redirect pulses exactly 1 cycle after the taken instruction is accepted, for 1 cycle.
- Throughput: 1/cycle while mem_ready high. mem_ready low: 1st extra beat into SKID, then ex_ready drops the following cycle.
- mem_* stable while mem_valid & !mem_ready.
- Back-to-back taken branches: second is squashed (arrives in redirect cycle); only first redirects.

## Test plan
- Stream: 4 ADD beats, ALUResult 0x10,0x20,0x30,0x40, mem_ready=1 -> mem_result same order, 1-cycle latency, ex_ready stays 1.
- Backpressure: mem_ready=0 for 3 cycles during stream of 0x1,0x2,0x3 -> 0x1 held on OUT, 0x2 in SKID, ex_ready=0 from next cycle, 0x3 held by EX; release -> 0x1,0x2,0x3 in order, none lost/duplicated.
- BEQ with ALUResult=1, target 0x100 -> pc_redirect=1 one cycle later, pc_target=0x100, mem_reg_write=0; ALUResult=0 -> no redirect.
- JAL, pc_plus4=0x48, rd=1, target 0x200 -> mem_result=0x48, fwd_valid=1 fwd_rd=1, redirect to 0x200; next EX beat (rd=5) in redirect cycle discarded.
- flush with both entries full and redirect_q=1 -> pc_redirect=0 that cycle, mem_valid=0 and ex_ready=1 next cycle.
- reset=0 mid-stream with SKID full -> all outputs at reset values next cycle; rd=0 write -> fwd_valid=0.
